// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel-shifter family: default sizes, mode
// encodings and the sequential right shifter's state encoding.
package barrel_pkg;

    // Default data width and matching shift-amount width (clog2 of WIDTH).
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned AMT_W_DEF = 3;

    // Shift mode encodings; 2'b11 is reserved and behaves as logical.
    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    // Sequential right shifter control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shr_state_e;

endpackage : barrel_pkg

// File: rtl/right_step.sv
// Single-position right shift/rotate step.
// Ports:
//   data_i  operand
//   mode_i  shift mode (logical, arithmetic, rotate; reserved acts as logical)
//   data_o  operand shifted right by one bit position
module right_step
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] data_o
);

    logic msb_in;

    // Bit shifted into the MSB position depends on the mode.
    always_comb begin
        msb_in = 1'b0;
        case (mode_i)
            MODE_ASR: msb_in = data_i[WIDTH-1];
            MODE_ROR: msb_in = data_i[0];
            default:  msb_in = 1'b0;
        endcase
    end

    assign data_o = {msb_in, data_i[WIDTH-1:1]};

endmodule : right_step

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter/rotator: one bit position per clock, with a
// start/busy/done handshake. Result is loaded into y only on entry to DONE.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, sampled only in IDLE
//   a      operand, captured on accepted start
//   amt    shift amount 0..WIDTH-1, captured on accepted start
//   mode   00 logical, 01 arithmetic, 10 rotate, 11 logical
//   busy   high while shifting
//   done   one-cycle pulse when y becomes valid
//   y      registered result, held until the next result
module seq_right_shifter
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    shr_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_data;

    right_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (data_q),
        .mode_i (mode_q),
        .data_o (step_data)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        y_d     = y_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d = a;
                    cnt_d  = amt;
                    mode_d = mode;
                    if (amt != AMT_W'(0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                        y_d     = a;
                    end
                end
            end
            ST_SHIFT: begin
                data_d = step_data;
                cnt_d  = cnt_q - AMT_W'(1);
                // Leaving at cnt==1 means the counter never wraps.
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                    y_d     = step_data;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next-state decode.
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_LSR;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule : seq_right_shifter

// File: tb/tb_seq_right_shifter.sv
// Self-checking bench for seq_right_shifter: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_seq_right_shifter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [2:0] amt;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [7:0] y;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [7:0]  prev_y;

    seq_right_shifter #(
        .WIDTH (8),
        .AMT_W (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .amt   (amt),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic.
    function automatic logic [7:0] ref_shift(input logic [7:0] av, input logic [2:0] nv,
                                             input logic [1:0] mv);
        logic signed [7:0] s;
        logic [15:0]       dbl;
        s   = av;
        dbl = {av, av} >> nv;
        case (mv)
            2'b01:   ref_shift = 8'(s >>> nv);
            2'b10:   ref_shift = dbl[7:0];
            default: ref_shift = av >> nv;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scramble inputs while the DUT is not in IDLE; they must be ignored.
    task automatic scramble;
        start = 1'($urandom);
        a     = 8'($urandom);
        amt   = 3'($urandom);
        mode  = 2'($urandom);
    endtask

    // One full operation, checking busy/done/y on every cycle.
    task automatic do_op(input logic [7:0] av, input logic [2:0] nv, input logic [1:0] mv);
        logic [7:0] exp;
        exp   = ref_shift(av, nv, mv);
        start = 1'b1;
        a     = av;
        amt   = nv;
        mode  = mv;
        tick();
        for (int j = 0; j < int'(nv); j++) begin
            check_eq("busy_shift", 32'(busy), 32'd1);
            check_eq("done_shift", 32'(done), 32'd0);
            check_eq("y_hold", 32'(y), 32'(prev_y));
            scramble();
            tick();
        end
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("y_result", 32'(y), 32'(exp));
        scramble();
        tick();
        check_eq("done_clear", 32'(done), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("y_keep", 32'(y), 32'(exp));
        start  = 1'b0;
        prev_y = exp;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        prev_y  = 8'h00;
        rst_n   = 1'b0;
        start   = 1'b1;
        a       = 8'hFF;
        amt     = 3'd2;
        mode    = 2'b00;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);

        // Directed cases from the known-answer list.
        do_op(8'h96, 3'd3, 2'b00);
        check_eq("lsr_96", 32'(y), 32'h12);
        do_op(8'h96, 3'd3, 2'b01);
        check_eq("asr_96", 32'(y), 32'hF2);
        do_op(8'h16, 3'd3, 2'b01);
        check_eq("asr_16", 32'(y), 32'h02);
        do_op(8'h96, 3'd3, 2'b10);
        check_eq("ror_96", 32'(y), 32'hD2);
        do_op(8'h81, 3'd7, 2'b10);
        check_eq("ror_81", 32'(y), 32'h03);
        do_op(8'h96, 3'd3, 2'b11);
        check_eq("rsv_96", 32'(y), 32'h12);
        for (int m = 0; m < 4; m++) begin
            do_op(8'h5A, 3'd0, 2'(m));
            check_eq("amt0", 32'(y), 32'h5A);
        end

        // Held start with amt=0 restarts every two cycles.
        start = 1'b1;
        a     = 8'h5A;
        amt   = 3'd0;
        mode  = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("held_done", 32'(done), 32'((i % 2) == 0));
            check_eq("held_busy", 32'(busy), 32'd0);
            check_eq("held_y", 32'(y), 32'h5A);
        end
        start  = 1'b0;
        prev_y = 8'h5A;

        // Second start during SHIFT is ignored; exactly one done pulse.
        start = 1'b1;
        a     = 8'hF0;
        amt   = 3'd5;
        mode  = 2'b00;
        tick();
        start = 1'b0;
        a     = 8'h0F;
        tick();
        start = 1'b1;
        amt   = 3'd1;
        tick();
        start = 1'b0;
        begin
            int unsigned pulses;
            pulses = 0;
            for (int i = 0; i < 10; i++) begin
                if (done) pulses++;
                tick();
            end
            check_eq("ignore_pulses", 32'(pulses), 32'd1);
        end
        check_eq("ignore_y", 32'(y), 32'h07);
        prev_y = 8'h07;

        // Reset mid-operation aborts with no done afterwards.
        start = 1'b1;
        a     = 8'hC3;
        amt   = 3'd6;
        mode  = 2'b10;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_y", 32'(y), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        begin
            int unsigned pulses;
            pulses = 0;
            for (int i = 0; i < 9; i++) begin
                tick();
                if (done || busy) pulses++;
            end
            check_eq("abort_quiet", 32'(pulses), 32'd0);
        end
        prev_y = 8'h00;
        do_op(8'hF0, 3'd4, 2'b01);
        check_eq("post_reset", 32'(y), 32'hFF);

        // Random operations.
        for (int i = 0; i < 300; i++) begin
            do_op(8'($urandom), 3'($urandom), 2'($urandom));
            if (($urandom % 4) == 0) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_right_shifter
